// File: rtl/prueba1_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : prueba1_ram_arbiter
// Description : Two-port Avalon-MM arbiter for a single-port 1-clk-latency RAM.
//               Optional macro PRUEBA1_RAM_ARB_ROUND_ROBIN_EN selects
//               round-robin tie-break (default: port 0 priority).
// Revision    : 1.0 - initial release
// ============================================================================
module prueba1_ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_chipselect,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic              m1_chipselect,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              r_last_grant;
    logic              r_cmd_port;
    logic              r_cmd_read;
    logic              r_clken;
    logic [1:0]        r_rdv;

    logic              w_req0;
    logic              w_req1;
    logic              w_any_req;
    logic              w_winner;
    logic              w_accept;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [BE_W-1:0]   w_sel_be;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_req0    = m0_chipselect & (m0_read | m0_write);
    assign w_req1    = m1_chipselect & (m1_read | m1_write);
    assign w_any_req = w_req0 | w_req1;

    always_comb begin
        w_winner = 1'b0;
        if (w_req0 && w_req1) begin
`ifdef PRUEBA1_RAM_ARB_ROUND_ROBIN_EN
            w_winner = ~r_last_grant;
`else
            w_winner = 1'b0;
`endif
        end else if (w_req1) begin
            w_winner = 1'b1;
        end
    end

    // Acceptance waits for the RAM clock enable so the first command after
    // reset never lands on a gated RAM.
    assign w_accept = reset_n & r_clken & (r_state == ST_IDLE) & w_any_req;

    assign m0_waitrequest = ~(w_accept & ~w_winner);
    assign m1_waitrequest = ~(w_accept &  w_winner);

    assign w_sel_write = w_winner ? m1_write      : m0_write;
    assign w_sel_addr  = w_winner ? m1_address    : m0_address;
    assign w_sel_be    = w_winner ? m1_byteenable : m0_byteenable;
    assign w_sel_wdata = w_winner ? m1_writedata  : m0_writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = r_cmd_read ? ST_DATA : ST_IDLE;
            ST_DATA:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_address    <= '0;
            ram_byteenable <= '0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_writedata  <= '0;
            r_clken        <= 1'b0;
            r_rdv          <= 2'b00;
            r_last_grant   <= 1'b1;
            r_cmd_port     <= 1'b0;
            r_cmd_read     <= 1'b0;
        end else begin
            r_clken        <= 1'b1;
            r_rdv          <= 2'b00;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            if (w_accept) begin
                ram_chipselect <= 1'b1;
                ram_write      <= w_sel_write;
                ram_address    <= w_sel_addr;
                ram_byteenable <= w_sel_be;
                ram_writedata  <= w_sel_wdata;
                r_last_grant   <= w_winner;
                r_cmd_port     <= w_winner;
                r_cmd_read     <= ~w_sel_write;
            end
            if (r_state == ST_ISSUE && r_cmd_read) begin
                r_rdv[r_cmd_port] <= 1'b1;
            end
        end
    end

    // Masking with reset_n drops a strobe whose DATA cycle coincides with reset.
    assign m0_readdatavalid = r_rdv[0] & reset_n;
    assign m1_readdatavalid = r_rdv[1] & reset_n;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign ram_clken        = r_clken;

endmodule
`default_nettype wire

// File: tb/tb_prueba1_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_prueba1_ram_arbiter
// Description : Directed self-checking bench with a behavioural RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prueba1_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_chipselect, m0_read, m0_write;
    logic [9:0]  m0_address;
    logic [3:0]  m0_byteenable;
    logic [31:0] m0_writedata;
    logic        m0_waitrequest, m0_readdatavalid;
    logic [31:0] m0_readdata;
    logic        m1_chipselect, m1_read, m1_write;
    logic [9:0]  m1_address;
    logic [3:0]  m1_byteenable;
    logic [31:0] m1_writedata;
    logic        m1_waitrequest, m1_readdatavalid;
    logic [31:0] m1_readdata;
    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prueba1_ram_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_chipselect(m0_chipselect), .m0_read(m0_read), .m0_write(m0_write),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_chipselect(m1_chipselect), .m1_read(m1_read), .m1_write(m1_write),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    // Single-port byte-enabled RAM with registered address (q valid next clk).
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    typedef struct packed {
        logic        port;
        logic        wr;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [0:9];

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic wreq(input logic p);
        return p ? m1_waitrequest : m0_waitrequest;
    endfunction

    function automatic logic rdv(input logic p);
        return p ? m1_readdatavalid : m0_readdatavalid;
    endfunction

    task automatic drive(input logic p, input logic wr, input logic [9:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        if (p) begin
            m1_chipselect = 1'b1; m1_read = ~wr; m1_write = wr;
            m1_address = a; m1_byteenable = be; m1_writedata = d;
        end else begin
            m0_chipselect = 1'b1; m0_read = ~wr; m0_write = wr;
            m0_address = a; m0_byteenable = be; m0_writedata = d;
        end
    endtask

    task automatic release_port(input logic p);
        if (p) begin m1_chipselect = 1'b0; m1_read = 1'b0; m1_write = 1'b0; end
        else   begin m0_chipselect = 1'b0; m0_read = 1'b0; m0_write = 1'b0; end
    endtask

    // Returns at the negedge of the accept cycle (or after the bound expires).
    task automatic wait_accept(input logic p, input string nm);
        logic acc = 1'b0;
        int   cyc = 0;
        while (!acc && cyc < 8) begin
            @(negedge clk);
            if (wreq(p) == 1'b0) acc = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        check1({nm, " accept"}, acc, 1'b1);
    endtask

    task automatic do_txn(input vec_t v, input string nm);
        @(posedge clk); #1;
        drive(v.port, v.wr, v.addr, v.be, v.wdata);
        wait_accept(v.port, nm);
        @(posedge clk); #1;
        release_port(v.port);
        @(negedge clk);
        check1({nm, " ram_cs"}, ram_chipselect, 1'b1);
        check1({nm, " ram_write"}, ram_write, v.wr);
        check32({nm, " ram_addr"}, {22'd0, ram_address}, {22'd0, v.addr});
        if (v.wr) begin
            check32({nm, " ram_wdata"}, ram_writedata, v.wdata);
        end else begin
            @(posedge clk);
            @(negedge clk);
            check1({nm, " rdv"}, rdv(v.port), 1'b1);
            check1({nm, " other_rdv"}, rdv(~v.port), 1'b0);
            check32({nm, " rdata"}, v.port ? m1_readdata : m0_readdata, v.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ep;
        int         k;

        vecs[0] = '{1'b0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 10'h005, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 10'h005, 4'h1, 32'h000000AA, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 10'h005, 4'hF, 32'h0,        32'hDEADBEAA};
        vecs[4] = '{1'b1, 1'b1, 10'h000, 4'hC, 32'hCAFEF00D, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 10'h000, 4'hF, 32'h0,        32'hCAFE0000};
        vecs[6] = '{1'b1, 1'b1, 10'h3FF, 4'hF, 32'hA5A5A5A5, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 10'h3FF, 4'hF, 32'h0,        32'hA5A5A5A5};
        vecs[8] = '{1'b0, 1'b1, 10'h200, 4'h6, 32'h11223344, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 10'h200, 4'hF, 32'h0,        32'h00223300};

        // Reset with both ports requesting
        reset_n = 1'b0;
        release_port(1'b0);
        release_port(1'b1);
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = 32'h0; m1_writedata = 32'h0;
        drive(1'b0, 1'b0, 10'h010, 4'hF, 32'h0);
        drive(1'b1, 1'b0, 10'h020, 4'hF, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst m0_wreq", m0_waitrequest, 1'b1);
        check1("rst m1_wreq", m1_waitrequest, 1'b1);
        check1("rst m0_rdv", m0_readdatavalid, 1'b0);
        check1("rst m1_rdv", m1_readdatavalid, 1'b0);
        check1("rst ram_cs", ram_chipselect, 1'b0);
        check1("rst ram_clken", ram_clken, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check1("post-rst ram_clken", ram_clken, 1'b1);
        check1("post-rst m0 accept", m0_waitrequest, 1'b0);
        check1("post-rst m1 held", m1_waitrequest, 1'b1);
        @(posedge clk); #1;
        release_port(1'b0);
        release_port(1'b1);
        @(negedge clk);
        check32("post-rst ram_addr", {22'd0, ram_address}, 32'h010);
        @(posedge clk);
        @(negedge clk);
        check1("post-rst m0_rdv", m0_readdatavalid, 1'b1);

        // Single-port transactions from the table
        for (int i = 0; i < 10; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Continuous contention: both ports hold reads
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 10'h010, 4'hF, 32'h0);
        drive(1'b1, 1'b0, 10'h020, 4'hF, 32'h0);
        k = 0;
        ep = 2'd0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c % 3 == 0) begin
`ifdef PRUEBA1_RAM_ARB_ROUND_ROBIN_EN
                ep = (k % 2 == 0) ? 2'd0 : 2'd1;
`else
                ep = 2'd0;
`endif
                k++;
            end
            check1($sformatf("cont c%0d m0_wreq", c), m0_waitrequest, !((c % 3 == 0) && ep == 2'd0));
            check1($sformatf("cont c%0d m1_wreq", c), m1_waitrequest, !((c % 3 == 0) && ep == 2'd1));
            if (c % 3 == 2) begin
                check1($sformatf("cont c%0d rdv", c), rdv(ep[0]), 1'b1);
                check32($sformatf("cont c%0d rdata", c), ram_readdata, 32'h0);
            end
            @(posedge clk); #1;
        end
        release_port(1'b0);
        release_port(1'b1);

        // Reset during the DATA cycle of an m1 read
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 10'h005, 4'hF, 32'h0);
        wait_accept(1'b1, "rstdata");
        @(posedge clk); #1;
        release_port(1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        check1("rstdata m1_rdv", m1_readdatavalid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check1("rstdata m1_rdv2", m1_readdatavalid, 1'b0);
        check1("rstdata ram_cs", ram_chipselect, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk);
        do_txn('{1'b1, 1'b0, 10'h005, 4'hF, 32'h0, 32'hDEADBEAA}, "retry");

        // Tie after a port-0 grant: m1 write vs m0 read at 0x3FF
        do_txn('{1'b0, 1'b0, 10'h005, 4'hF, 32'h0, 32'hDEADBEAA}, "pre-tie");
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 10'h3FF, 4'hF, 32'h12345678);
        drive(1'b0, 1'b0, 10'h3FF, 4'hF, 32'h0);
        @(negedge clk);
`ifdef PRUEBA1_RAM_ARB_ROUND_ROBIN_EN
        check1("tie m1 wins", m1_waitrequest, 1'b0);
        check1("tie m0 held", m0_waitrequest, 1'b1);
        @(posedge clk); #1;
        release_port(1'b1);
        @(negedge clk);
        check1("tie ram_write", ram_write, 1'b1);
        check32("tie ram_wdata", ram_writedata, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        check1("tie m0 accept", m0_waitrequest, 1'b0);
        @(posedge clk); #1;
        release_port(1'b0);
        @(posedge clk);
        @(negedge clk);
        check1("tie m0_rdv", m0_readdatavalid, 1'b1);
        check32("tie m0 rdata", m0_readdata, 32'h12345678);
`else
        check1("tie m0 wins", m0_waitrequest, 1'b0);
        check1("tie m1 held", m1_waitrequest, 1'b1);
        @(posedge clk); #1;
        release_port(1'b0);
        @(posedge clk);
        @(negedge clk);
        check1("tie m0_rdv", m0_readdatavalid, 1'b1);
        check32("tie m0 rdata", m0_readdata, 32'hA5A5A5A5);
        @(posedge clk);
        @(negedge clk);
        check1("tie m1 accept", m1_waitrequest, 1'b0);
        @(posedge clk); #1;
        release_port(1'b1);
        @(negedge clk);
        check32("tie ram_wdata", ram_writedata, 32'h12345678);
        do_txn('{1'b0, 1'b0, 10'h3FF, 4'hF, 32'h0, 32'h12345678}, "tie readback");
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
